// File: rtl/miriscv_fetch_pkg.sv
// Types shared between the fetch stage and its instruction buffer.
package miriscv_fetch_pkg;
   import miriscv_pkg::*;

   typedef enum logic {FETCH_BOOT, FETCH_RUN} fetch_state_e;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide widths shared by every miriscv pipeline stage.
package miriscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {instr, pc}; flush wins over push.
module miriscv_fetch_fifo
   import miriscv_pkg::*;
   import miriscv_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

   // The fetch credit scheme must make this impossible.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
      !(push && !pop && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/miriscv_fetch_stage.sv
// miriscv instruction fetch: credit-limited sequential imem requests, in-order
// response buffering, boot/stall/kill handling for the decode stage.
module miriscv_fetch_stage
   import miriscv_pkg::*;
   import miriscv_fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic [XLEN-1:0] boot_addr_i,
   output logic            instr_req_o,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_rvalid_i,
   input  logic [ILEN-1:0] instr_rdata_i,
   output logic [ILEN-1:0] f_instr_o,
   output logic [XLEN-1:0] f_current_pc_o,
   output logic [XLEN-1:0] f_next_pc_o,
   output logic            f_valid_o,
   input  logic [XLEN-1:0] cu_pc_bra_i,
   input  logic            cu_boot_addr_load_en_i,
   input  logic            cu_stall_f_i,
   input  logic            cu_kill_f_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state, state_next;
   logic [XLEN-1:0] fetch_pc, resp_pc;
   logic [CW-1:0]   outstanding, drop_cnt, count;
   logic [CW:0]     credit;
   logic            empty, run, pop, kill, boot_flush, flush, issue, rsp, push;
   fetch_entry_t    head;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state <= FETCH_BOOT;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH_BOOT: if (!cu_boot_addr_load_en_i) state_next = FETCH_RUN;
         FETCH_RUN:  if (cu_boot_addr_load_en_i)  state_next = FETCH_BOOT;
         default:    state_next = FETCH_BOOT;
      endcase
   end

   assign run        = (state == FETCH_RUN);
   assign f_valid_o  = ~empty;
   assign pop        = f_valid_o & ~cu_stall_f_i;
   assign kill       = run & cu_kill_f_i & ~cu_stall_f_i;
   assign boot_flush = run & cu_boot_addr_load_en_i;
   assign flush      = kill | boot_flush;

   // Credit counts in-flight plus buffered slots, so every response has room.
   assign credit = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
   assign issue  = run & ~flush & (credit < (CW+1)'(FIFO_DEPTH));

   // A response with nothing outstanding (e.g. after reset) is ignored.
   assign rsp  = instr_rvalid_i & (outstanding != '0);
   assign push = rsp & (drop_cnt == '0) & ~flush;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         fetch_pc    <= boot_addr_i;
         resp_pc     <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(rsp);
         if (flush)
            drop_cnt <= outstanding - CW'(rsp);
         else if (rsp && drop_cnt != '0)
            drop_cnt <= drop_cnt - CW'(1);

         if (!run || boot_flush) begin
            fetch_pc <= boot_addr_i;
            resp_pc  <= boot_addr_i;
         end else if (kill) begin
            fetch_pc <= cu_pc_bra_i;
            resp_pc  <= cu_pc_bra_i;
         end else begin
            if (issue) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)  resp_pc  <= resp_pc + XLEN'(4);
         end
      end
   end

   miriscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wdata   ({instr_rdata_i, resp_pc}),
      .head    (head),
      .count   (count),
      .empty   (empty)
   );

   assign instr_req_o    = issue;
   assign instr_addr_o   = issue ? fetch_pc : '0;
   assign f_instr_o      = f_valid_o ? head.instr : '0;
   assign f_current_pc_o = f_valid_o ? head.pc : '0;
   assign f_next_pc_o    = f_valid_o ? head.pc + XLEN'(4) : '0;

   a_credit: assert property (@(posedge clk_i) disable iff (!arstn_i)
      ({1'b0, outstanding} + {1'b0, count}) <= (CW+1)'(FIFO_DEPTH));
endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Directed table plus corner-case sequences for the miriscv fetch stage.
module tb_miriscv_fetch_stage;
   localparam int FD = 4;
   localparam logic [31:0] B = 32'h8000_0000;

   logic        clk = 1'b0, arstn = 1'b0;
   logic [31:0] boot_addr, addr, rdata, instr, pc, next_pc, bra;
   logic        req, rvalid, valid, boot_en, stall, kill;

   miriscv_fetch_stage #(.FIFO_DEPTH(FD)) dut (
      .clk_i(clk), .arstn_i(arstn), .boot_addr_i(boot_addr),
      .instr_req_o(req), .instr_addr_o(addr),
      .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
      .f_instr_o(instr), .f_current_pc_o(pc), .f_next_pc_o(next_pc), .f_valid_o(valid),
      .cu_pc_bra_i(bra), .cu_boot_addr_load_en_i(boot_en),
      .cu_stall_f_i(stall), .cu_kill_f_i(kill)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] a; int due; } req_t;
   typedef struct {
      logic boot_en; logic stall; logic req; logic [31:0] aoff; logic valid; logic [31:0] poff;
   } vec_t;

   req_t        pend[$];
   vec_t        tbl[18];
   int          cyc, lat, last_due, errors, checks, pops, max_out;
   bit          rand_lat, sb_on;
   logic [31:0] exp_pc, s_addr, s_pc, s_next, s_instr, ea, ep;
   logic        s_req, s_valid;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // One clock: imem model drives response, sample at negedge, scoreboard pops.
   task automatic cycle();
      int d;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         rvalid = 1'b1; rdata = mk(pend[0].a); void'(pend.pop_front());
      end else begin
         rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      s_req = req; s_addr = addr; s_valid = valid; s_pc = pc; s_next = next_pc; s_instr = instr;
      if (s_req) begin
         d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         pend.push_back('{s_addr, d});
         if (pend.size() > max_out) max_out = pend.size();
      end
      if (sb_on && s_valid && !stall) begin
         pops++;
         chk("sb pc", s_pc, exp_pc);
         chk("sb next_pc", s_next, exp_pc + 32'd4);
         chk("sb instr", s_instr, mk(exp_pc));
         exp_pc = kill ? bra : exp_pc + 32'd4;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic boot(input logic [31:0] a, input int l);
      int n;
      sb_on = 0; rand_lat = 0; kill = 0; stall = 0; boot_addr = a; boot_en = 1;
      n = 0;
      do begin cycle(); n++; end while ((n < 2 || pend.size() > 0) && n < 30);
      if (pend.size() > 0) chk("boot drain", pend.size(), 0);
      lat = l; exp_pc = a; sb_on = 1; boot_en = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // boot_en, stall, req, addr-B, valid, pc-B (1-cycle imem)
      tbl[0]  = '{1, 0, 0, 0, 0, 0};          tbl[1]  = '{1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 0};          tbl[3]  = '{0, 0, 1, 'h00, 0, 0};
      tbl[4]  = '{0, 0, 1, 'h04, 0, 0};       tbl[5]  = '{0, 0, 1, 'h08, 1, 'h00};
      tbl[6]  = '{0, 0, 1, 'h0C, 1, 'h04};    tbl[7]  = '{0, 0, 1, 'h10, 1, 'h08};
      tbl[8]  = '{0, 1, 1, 'h14, 1, 'h0C};    tbl[9]  = '{0, 1, 1, 'h18, 1, 'h0C};
      tbl[10] = '{0, 1, 0, 0, 1, 'h0C};       tbl[11] = '{0, 1, 0, 0, 1, 'h0C};
      tbl[12] = '{0, 1, 0, 0, 1, 'h0C};       tbl[13] = '{0, 0, 1, 'h1C, 1, 'h0C};
      tbl[14] = '{0, 0, 1, 'h20, 1, 'h10};    tbl[15] = '{0, 0, 1, 'h24, 1, 'h14};
      tbl[16] = '{0, 0, 1, 'h28, 1, 'h18};    tbl[17] = '{0, 0, 1, 'h2C, 1, 'h1C};

      errors = 0; checks = 0; pops = 0; max_out = 0; cyc = 0; lat = 1; last_due = 0;
      rand_lat = 0; sb_on = 0; exp_pc = 0;
      boot_addr = B; boot_en = 1; stall = 0; kill = 0; bra = 0; rvalid = 0; rdata = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req", req, 0);         chk("rst addr", addr, 0);
      chk("rst valid", valid, 0);     chk("rst pc", pc, 0);
      chk("rst next_pc", next_pc, 0); chk("rst instr", instr, 0);
      @(posedge clk); #1;
      arstn = 1;

      // Boot, sequential fetch, 5-cycle stall with full buffer
      foreach (tbl[i]) begin
         boot_en = tbl[i].boot_en; stall = tbl[i].stall;
         cycle();
         ea = tbl[i].req   ? B + tbl[i].aoff : 32'h0;
         ep = tbl[i].valid ? B + tbl[i].poff : 32'h0;
         chk($sformatf("row%0d req", i), s_req, tbl[i].req);
         chk($sformatf("row%0d addr", i), s_addr, ea);
         chk($sformatf("row%0d valid", i), s_valid, tbl[i].valid);
         chk($sformatf("row%0d pc", i), s_pc, ep);
         chk($sformatf("row%0d next_pc", i), s_next, tbl[i].valid ? ep + 32'd4 : 32'h0);
         chk($sformatf("row%0d instr", i), s_instr, tbl[i].valid ? mk(ep) : 32'h0);
      end
      stall = 0;

      // Kill at head 0x100 with two requests in flight
      boot(32'h100, 2);
      repeat (4) cycle();
      chk("t3 head valid", valid, 1);
      chk("t3 head pc", pc, 32'h100);
      chk("t3 in flight", pend.size(), 2);
      kill = 1; bra = 32'h200;
      cycle();
      chk("t3 kill-cycle req", s_req, 0);
      kill = 0;
      cycle();
      chk("t3 target req", s_req, 1);
      chk("t3 target addr", s_addr, 32'h200);
      chk("t3 flushed", s_valid, 0);
      for (int i = 0; i < 8 && !s_valid; i++) cycle();
      chk("t3 first valid pc", s_pc, 32'h200);
      cycle();
      chk("t3 second valid pc", s_pc, 32'h204);

      // Kill held with stall for 3 cycles, honoured when stall drops
      lat = 1;
      repeat (6) cycle();
      for (int i = 0; i < 10 && !valid; i++) cycle();
      kill = 1; stall = 1; bra = 32'h4000;
      repeat (3) begin
         cycle();
         chk("t4 held valid", s_valid, 1);
         chk("t4 held pc", s_pc, exp_pc);
      end
      stall = 0;
      cycle();
      chk("t4 kill-cycle req", s_req, 0);
      chk("t4 exp redirected", exp_pc, 32'h4000);
      kill = 0;
      cycle();
      chk("t4 target req", s_req, 1);
      chk("t4 target addr", s_addr, 32'h4000);
      repeat (6) cycle();
      chk("t4 progress", exp_pc, 32'h4014);

      // Random latency, stall and kill against the architectural sequence
      boot(32'h2000, 1);
      rand_lat = 1; pops = 0; max_out = 0;
      for (int i = 0; i < 600; i++) begin
         stall = ($urandom_range(0, 9) < 3);
         kill  = valid && ($urandom_range(0, 9) == 0);
         bra   = 32'h1_0000 + ($urandom_range(0, 1023) << 2);
         cycle();
      end
      stall = 0; kill = 0;
      chk("t5 outstanding<=depth", max_out <= FD, 1);
      chk("t5 progress", pops > 100, 1);

      // Reset with requests outstanding, then late responses
      boot(32'h300, 3);
      for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
      chk("t6 outstanding", pend.size() >= 2, 1);
      sb_on = 0; boot_en = 1;
      arstn = 0;
      #1;
      chk("t6 rst req", req, 0);     chk("t6 rst addr", addr, 0);
      chk("t6 rst valid", valid, 0); chk("t6 rst pc", pc, 0);
      chk("t6 rst next_pc", next_pc, 0);
      cycle();
      arstn = 1;
      boot(32'h300, 1);
      chk("t6 stale dropped", s_valid, 0);
      cycle();
      cycle();
      chk("t6 restart req", s_req, 1);
      chk("t6 restart addr", s_addr, 32'h300);
      repeat (6) cycle();
      chk("t6 delivering", s_valid, 1);
      chk("t6 progress", exp_pc > 32'h300, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
